i2c_slave_reg_ctrl: RTL

Byte-level transaction controller that sits behind the i2c_slave bit engine and sequences its accesses to a small local register file.
- Decodes the address byte and decides ACK/NACK for every received byte.
- Manages an auto-incrementing register pointer and issues register write and read strobes.
- Prefetches read data for the slave to shift out.
- Runs entirely in the system clock domain; the bit engine delivers synchronised, single-cycle event pulses.

---
 rtl/i2c_slave_reg_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/i2c_slave_reg_ctrl.sv
// Byte-level transaction controller behind an I2C slave bit engine: address decode,
// ACK/NACK decisions, an auto-incrementing register pointer and read-data prefetch.
module i2c_slave_reg_ctrl #(
  parameter logic [6:0] DEV_ADDR = 7'h50,
  parameter int         NREGS    = 16,
  parameter int         ADDR_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              evt_start,
  input  logic              evt_stop,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              ack_valid,
  output logic              ack,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_take,
  input  logic              tx_nack,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [7:0]        reg_rdata,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE, ADDR, PTR, WRITE, RD_FETCH, RD_WAIT, RD_HOLD, IGNORE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NREGS - 1);

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] ptr_inc;
  logic              ptr_ok;

  // Pointer wraps modulo NREGS, which need not be a power of two.
  assign ptr_inc = (ptr == LAST_REG) ? '0 : ptr + 1'b1;
  assign ptr_ok  = ({24'd0, rx_data} < 32'(NREGS));

  // The read strobe is issued on entry to RD_FETCH so that reg_rdata is valid
  // while in RD_WAIT, where it is captured into tx_data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      ack_valid <= 1'b0;
      ack       <= 1'b0;
      tx_valid  <= 1'b0;
      tx_data   <= 8'h00;
      reg_addr  <= '0;
      reg_wdata <= 8'h00;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      ack_valid <= 1'b0;
      ack       <= 1'b0;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      if (evt_start) begin
        state    <= ADDR;
        tx_valid <= 1'b0;
        busy     <= 1'b0;
      end else if (evt_stop) begin
        state    <= IDLE;
        tx_valid <= 1'b0;
        busy     <= 1'b0;
      end else begin
        case (state)
          ADDR: begin
            if (rx_valid) begin
              ack_valid <= 1'b1;
              if (rx_data[7:1] == DEV_ADDR) begin
                ack  <= 1'b1;
                busy <= 1'b1;
                if (rx_data[0]) begin
                  state    <= RD_FETCH;
                  reg_re   <= 1'b1;
                  reg_addr <= ptr;
                end else begin
                  state <= PTR;
                end
              end else begin
                state <= IGNORE;
              end
            end
          end
          PTR: begin
            if (rx_valid) begin
              ack_valid <= 1'b1;
              if (ptr_ok) begin
                ptr   <= rx_data[ADDR_W-1:0];
                ack   <= 1'b1;
                state <= WRITE;
              end else begin
                busy  <= 1'b0;
                state <= IGNORE;
              end
            end
          end
          WRITE: begin
            if (rx_valid) begin
              ack_valid <= 1'b1;
              ack       <= 1'b1;
              reg_we    <= 1'b1;
              reg_addr  <= ptr;
              reg_wdata <= rx_data;
              ptr       <= ptr_inc;
            end
          end
          RD_FETCH: state <= RD_WAIT;
          RD_WAIT: begin
            tx_data  <= reg_rdata;
            tx_valid <= 1'b1;
            state    <= RD_HOLD;
          end
          RD_HOLD: begin
            if (tx_take) begin
              tx_valid <= 1'b0;
              ptr      <= ptr_inc;
              reg_re   <= 1'b1;
              reg_addr <= ptr_inc;
              state    <= RD_FETCH;
            end else if (tx_nack) begin
              tx_valid <= 1'b0;
              busy     <= 1'b0;
              ptr      <= ptr_inc;
              state    <= IGNORE;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
